fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined datapath. Owns the program counter, drives the instruction-memory address, and registers the fetched 16-bit instruction, whose opcode/function fields feed the `control` decoder directly downstream. Handles load-use stalls, taken-branch/jump redirects with flushes, and the HALT opcode (4'b1111). Keeps a saturating count of valid fetches for bring-up.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pc_unit.sv | 41 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction field bounds, special opcodes and
// the fetch-stage state encoding. The control decoder imports the same constants.
package pipe_pkg;

    localparam int INSTR_W = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int FUN_MSB = 3;
    localparam int FUN_LSB = 0;

    localparam logic [3:0]         OP_HALT   = 4'b1111;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter with its +2 incrementer and next-PC selection.
// Redirect beats stall, and stall beats a halt hold.
module pc_unit #(
    parameter int unsigned       PC_W     = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic            stall,
    input  logic            hold,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // The increment wraps naturally at the top of the address space.
    assign pc_plus2 = pc_q + PC_W'(2);
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_plus2;
        if (pc_src) begin
            pc_d = branch_target;
        end else if (stall || hold) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: stalls, redirect flushes, HALT freeze,
// and a saturating count of instructions latched valid into IF/ID.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                stall,
    input  logic                pc_src,
    input  logic [PC_W-1:0]     branch_target,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [PC_W-1:0]     if_id_pc_plus2,
    output logic                if_id_valid,
    output logic [3:0]          op_code,
    output logic [3:0]          fun_code,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    fetch_state_e        state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]     pc2_q, pc2_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_plus2;
    logic                is_halt_op;
    logic                pc_hold;

    assign is_halt_op = (imem_data[OP_MSB:OP_LSB] == OP_HALT);
    // The PC freezes both once halted and on the edge the HALT itself is latched.
    assign pc_hold    = (state_q == HALTED) || is_halt_op;

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .stall         (stall),
        .hold          (pc_hold),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus2      (pc_plus2)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (pc_src) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    instr_d = imem_data;
                    pc2_d   = pc_plus2;
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (is_halt_op) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr      = pc;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc2_q;
    assign if_id_valid    = valid_q;
    assign op_code        = instr_q[OP_MSB:OP_LSB];
    assign fun_code       = instr_q[FUN_MSB:FUN_LSB];
    assign halted         = (state_q == HALTED);
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second instance with a 2-bit counter
// shares the stimulus so counter saturation is exercised alongside normal flow.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pcSrc;
    logic [15:0] branchTarget;

    logic [15:0] imemAddr,  imemData;
    logic [15:0] ifIdInstr, ifIdPc2;
    logic        ifIdValid, halted;
    logic [3:0]  opCode, funCode;
    logic [15:0] fetchCount;

    logic [15:0] imemAddrS, imemDataS;
    logic [15:0] ifIdInstrS, ifIdPc2S;
    logic        ifIdValidS, haltedS;
    logic [3:0]  opCodeS, funCodeS;
    logic [1:0]  fetchCountS;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Program image: straight line at 0x0, HALTs at 0x8/0x22/0x42, wrap test at 0xFFFE.
    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1000;
            16'h0002: return 16'h2001;
            16'h0004: return 16'hA002;
            16'h0006: return 16'h3003;
            16'h0008: return 16'hF000;
            16'h0020: return 16'h4004;
            16'h0022: return 16'hF000;
            16'h0040: return 16'h5005;
            16'h0042: return 16'hF000;
            16'hFFFE: return 16'h7007;
            default:  return 16'h0EEE;
        endcase
    endfunction

    assign imemData  = imem(imemAddr);
    assign imemDataS = imem(imemAddrS);

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imemAddr),
        .imem_data      (imemData),
        .stall          (stall),
        .pc_src         (pcSrc),
        .branch_target  (branchTarget),
        .if_id_instr    (ifIdInstr),
        .if_id_pc_plus2 (ifIdPc2),
        .if_id_valid    (ifIdValid),
        .op_code        (opCode),
        .fun_code       (funCode),
        .halted         (halted),
        .fetch_count    (fetchCount)
    );

    fetch_stage #(.CNT_W(2)) dutSat (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imemAddrS),
        .imem_data      (imemDataS),
        .stall          (stall),
        .pc_src         (pcSrc),
        .branch_target  (branchTarget),
        .if_id_instr    (ifIdInstrS),
        .if_id_pc_plus2 (ifIdPc2S),
        .if_id_valid    (ifIdValidS),
        .op_code        (opCodeS),
        .fun_code       (funCodeS),
        .halted         (haltedS),
        .fetch_count    (fetchCountS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string step, input logic [15:0] expAddr,
                            input logic [15:0] expInstr, input logic [15:0] expPc2,
                            input logic expValid, input logic expHalted,
                            input int expCount);
        logic [3:0] expOp;
        logic [3:0] expFun;
        int         expSat;
        expOp  = expInstr[15:12];
        expFun = expInstr[3:0];
        expSat = (expCount > 3) ? 3 : expCount;
        checkOutput({step, ".addr"},   32'(imemAddr),    32'(expAddr));
        checkOutput({step, ".instr"},  32'(ifIdInstr),   32'(expInstr));
        checkOutput({step, ".pc2"},    32'(ifIdPc2),     32'(expPc2));
        checkOutput({step, ".valid"},  32'(ifIdValid),   32'(expValid));
        checkOutput({step, ".halted"}, 32'(halted),      32'(expHalted));
        checkOutput({step, ".op"},     32'(opCode),      32'(expOp));
        checkOutput({step, ".fun"},    32'(funCode),     32'(expFun));
        checkOutput({step, ".count"},  32'(fetchCount),  32'(expCount));
        checkOutput({step, ".satcnt"}, 32'(fetchCountS), 32'(expSat));
    endtask

    // Drive inputs for the coming edge, then sample 1ns after it.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic [15:0] t);
        rst          = r;
        stall        = s;
        pcSrc        = p;
        branchTarget = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pcSrc = 1'b0; branchTarget = 16'h0;

        applyStimulus(1, 0, 0, 16'h0);
        checkAll("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        // Straight-line fetch from 0x0
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch0", 16'h0002, 16'h1000, 16'h0002, 1, 0, 1);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch2", 16'h0004, 16'h2001, 16'h0004, 1, 0, 2);

        // Two stall cycles at PC=0x4
        applyStimulus(0, 1, 0, 16'h0);
        checkAll("stall1", 16'h0004, 16'h2001, 16'h0004, 1, 0, 2);
        applyStimulus(0, 1, 0, 16'h0);
        checkAll("stall2", 16'h0004, 16'h2001, 16'h0004, 1, 0, 2);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch4", 16'h0006, 16'hA002, 16'h0006, 1, 0, 3);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch6", 16'h0008, 16'h3003, 16'h0008, 1, 0, 4);

        // Redirect with stall at PC=0x8 (HALT on imem must be ignored)
        applyStimulus(0, 1, 1, 16'h0040);
        checkAll("redir40", 16'h0040, 16'h0000, 16'h0008, 0, 0, 4);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch40", 16'h0042, 16'h5005, 16'h0042, 1, 0, 5);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("halt42", 16'h0042, 16'hF000, 16'h0044, 1, 1, 6);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 16'h0);
            checkAll("haltHold", 16'h0042, 16'hF000, 16'h0044, 1, 1, 6);
        end

        // Redirect out of HALTED
        applyStimulus(0, 0, 1, 16'h0020);
        checkAll("redir20", 16'h0020, 16'h0000, 16'h0044, 0, 0, 6);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetch20", 16'h0022, 16'h4004, 16'h0022, 1, 0, 7);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("halt22", 16'h0022, 16'hF000, 16'h0024, 1, 1, 8);
        applyStimulus(0, 1, 0, 16'h0);
        checkAll("haltStall", 16'h0022, 16'hF000, 16'h0024, 1, 1, 8);

        // Reset while halted and coincident with a redirect
        applyStimulus(1, 0, 1, 16'h0040);
        checkAll("rstHalt", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        // Wrap at the top of the address space
        applyStimulus(0, 0, 1, 16'hFFFE);
        checkAll("redirFFFE", 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetchFFFE", 16'h0000, 16'h7007, 16'h0000, 1, 0, 1);
        applyStimulus(0, 0, 0, 16'h0);
        checkAll("fetchWrap", 16'h0002, 16'h1000, 16'h0002, 1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
